// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decodes the RV32I subset into an ID/EX control register,
// inserts load-use bubbles and honours hold/flush. Optional macro: CTRL_PERF_CNT_EN.
module pipelined_control_unit #(
    parameter int unsigned ALUOP_W      = 2,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  id_ready,
    output logic                  out_valid,
    output logic                  RegWrite,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  ALUSrc,
    output logic                  MemToReg,
    output logic [ALUOP_W-1:0]    ALUOp,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           bubble_count
`endif
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (STALL_CYCLES > 1) ? CNT_W'(STALL_CYCLES - 2) : '0;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               jump;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_to_reg;
    } ctrl_t;

    typedef enum logic {RUN, STALL} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  illegal_q, illegal_d;

    ctrl_t dec;
    logic  known;
    logic  rs1_used;
    logic  rs2_used;
    logic  hazard;

    // Opcode decode plus which source registers the instruction actually reads
    always_comb begin
        dec      = '0;
        known    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(2'b10);
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                rs1_used       = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALUOP_W'(2'b01);
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_W'(2'b11);
                rs1_used      = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                rs1_used      = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign hazard = in_valid && valid_q && ctrl_q.mem_read && (ex_rd_q != '0) &&
                    ((rs1_used && (ex_rd_q == rs1)) || (rs2_used && (ex_rd_q == rs2)));

    // Next-state and fetch-hold; rst, flush, stall_in, stall, decode in priority order
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        ex_rd_d   = ex_rd_q;
        illegal_d = illegal_q;
        id_ready  = 1'b1;

        if (rst) begin
            id_ready = 1'b1;
        end else if (flush) begin
            state_d   = RUN;
            cnt_d     = '0;
            ctrl_d    = '0;
            valid_d   = 1'b0;
            ex_rd_d   = '0;
            illegal_d = 1'b0;
        end else if (stall_in) begin
            id_ready = 1'b0;
        end else if (state_q == STALL) begin
            id_ready  = 1'b0;
            ctrl_d    = '0;
            valid_d   = 1'b0;
            ex_rd_d   = '0;
            illegal_d = 1'b0;
            if (cnt_q == '0) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (hazard) begin
            id_ready  = 1'b0;
            ctrl_d    = '0;
            valid_d   = 1'b0;
            ex_rd_d   = '0;
            illegal_d = 1'b0;
            if (STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = CNT_INIT;
            end
        end else if (in_valid && known) begin
            ctrl_d    = dec;
            valid_d   = 1'b1;
            ex_rd_d   = rd;
            illegal_d = 1'b0;
        end else begin
            ctrl_d    = '0;
            valid_d   = 1'b0;
            ex_rd_d   = '0;
            illegal_d = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            ex_rd_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            ex_rd_q   <= ex_rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid = valid_q;
    assign RegWrite  = ctrl_q.reg_write;
    assign MemRead   = ctrl_q.mem_read;
    assign MemWrite  = ctrl_q.mem_write;
    assign Branch    = ctrl_q.branch;
    assign Jump      = ctrl_q.jump;
    assign ALUSrc    = ctrl_q.alu_src;
    assign MemToReg  = ctrl_q.mem_to_reg;
    assign ALUOp     = ctrl_q.alu_op;
    assign ex_rd     = ex_rd_q;
    assign illegal   = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic        bubble_inc;
    logic [31:0] bubble_count_q;

    // Counts only hazard-driven bubbles; flush and downstream hold do not count
    assign bubble_inc = !flush && !stall_in && ((state_q == STALL) || hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count_q <= '0;
        end else if (bubble_inc) begin
            bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: two instances (STALL_CYCLES=1 and 3) on shared inputs.
module tb_pipelined_control_unit;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // {out_valid, RegWrite, MemRead, MemWrite, Branch, Jump, ALUSrc, ALUOp[1:0], MemToReg, illegal}
    localparam logic [10:0] W_R    = 11'b11000001000;
    localparam logic [10:0] W_LW   = 11'b11100010010;
    localparam logic [10:0] W_SW   = 11'b10010010000;
    localparam logic [10:0] W_BEQ  = 11'b10001000100;
    localparam logic [10:0] W_ADDI = 11'b11000011100;
    localparam logic [10:0] W_JAL  = 11'b11000100000;
    localparam logic [10:0] W_JALR = 11'b11000110000;
    localparam logic [10:0] W_LUI  = 11'b11000010000;
    localparam logic [10:0] W_BUB  = 11'b00000000000;
    localparam logic [10:0] W_ILL  = 11'b00000000001;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       stall_in;
    logic       flush;

    logic       id_ready [2];
    logic       ov       [2];
    logic       rw       [2];
    logic       mr       [2];
    logic       mw       [2];
    logic       br       [2];
    logic       jp       [2];
    logic       as       [2];
    logic       mtr      [2];
    logic       ill      [2];
    logic [1:0] aluop    [2];
    logic [4:0] ex_rd    [2];
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] bc [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(.ALUOP_W(2), .REG_ADDR_W(5), .STALL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .stall_in(stall_in), .flush(flush),
        .id_ready(id_ready[0]), .out_valid(ov[0]), .RegWrite(rw[0]), .MemRead(mr[0]),
        .MemWrite(mw[0]), .Branch(br[0]), .Jump(jp[0]), .ALUSrc(as[0]),
        .MemToReg(mtr[0]), .ALUOp(aluop[0]), .ex_rd(ex_rd[0]), .illegal(ill[0])
`ifdef CTRL_PERF_CNT_EN
        , .bubble_count(bc[0])
`endif
    );

    pipelined_control_unit #(.ALUOP_W(2), .REG_ADDR_W(5), .STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .stall_in(stall_in), .flush(flush),
        .id_ready(id_ready[1]), .out_valid(ov[1]), .RegWrite(rw[1]), .MemRead(mr[1]),
        .MemWrite(mw[1]), .Branch(br[1]), .Jump(jp[1]), .ALUSrc(as[1]),
        .MemToReg(mtr[1]), .ALUOp(aluop[1]), .ex_rd(ex_rd[1]), .illegal(ill[1])
`ifdef CTRL_PERF_CNT_EN
        , .bubble_count(bc[1])
`endif
    );

    function automatic logic [10:0] word(input int k);
        return {ov[k], rw[k], mr[k], mw[k], br[k], jp[k], as[k], aluop[k], mtr[k], ill[k]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d);
        in_valid = v;
        opcode   = op;
        rs1      = a;
        rs2      = b;
        rd       = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  sweep_op  [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_JAL, OP_JALR, OP_LUI};
    logic [10:0] sweep_exp [8] = '{W_R, W_LW, W_SW, W_BEQ, W_ADDI, W_JAL, W_JALR, W_LUI};

    initial begin
        rst      = 1'b1;
        stall_in = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("rst_id_ready", 32'(id_ready[0]), 32'd1);
        check("rst_word", 32'(word(0)), 32'(W_BUB));
        check("rst_ex_rd", 32'(ex_rd[0]), 32'd0);
        rst = 1'b0;

        // Decode sweep
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sweep_op[i], 5'd2, 5'd3, 5'd1);
            #1;
            check($sformatf("sweep_ready_%0d", i), 32'(id_ready[0]), 32'd1);
            tick();
            check($sformatf("sweep_word_%0d", i), 32'(word(0)), 32'(sweep_exp[i]));
            check($sformatf("sweep_rd_%0d", i), 32'(ex_rd[0]), 32'd1);
        end
        drive(1'b1, OP_BAD, 5'd2, 5'd3, 5'd1);
        tick();
        check("illegal_pulse", 32'(word(0)), 32'(W_ILL));
        check("illegal_pulse_s3", 32'(word(1)), 32'(W_ILL));
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("illegal_clear", 32'(word(0)), 32'(W_BUB));

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Load-use, single bubble
        drive(1'b1, OP_LW, 5'd0, 5'd0, 5'd5);
        tick();
        check("lu1_lw", 32'(word(0)), 32'(W_LW));
        drive(1'b1, OP_R, 5'd5, 5'd6, 5'd8);
        #1;
        check("lu1_hold", 32'(id_ready[0]), 32'd0);
        tick();
        check("lu1_bubble", 32'(word(0)), 32'(W_BUB));
        check("lu1_bubble_rd", 32'(ex_rd[0]), 32'd0);
        check("lu1_release", 32'(id_ready[0]), 32'd1);
        tick();
        check("lu1_add", 32'(word(0)), 32'(W_R));
        check("lu1_add_rd", 32'(ex_rd[0]), 32'd8);
`ifdef CTRL_PERF_CNT_EN
        check("lu1_count", bc[0], 32'd1);
`endif

        // Load to x0 never stalls
        drive(1'b1, OP_LW, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd9);
        #1;
        check("x0_ready", 32'(id_ready[0]), 32'd1);
        tick();
        check("x0_add", 32'(word(0)), 32'(W_R));

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Load-use, three bubbles
        drive(1'b1, OP_LW, 5'd0, 5'd0, 5'd7);
        tick();
        drive(1'b1, OP_SW, 5'd0, 5'd7, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("lu3_hold_%0d", k), 32'(id_ready[1]), 32'd0);
            tick();
            check($sformatf("lu3_bubble_%0d", k), 32'(word(1)), 32'(W_BUB));
        end
        check("lu3_release", 32'(id_ready[1]), 32'd1);
        tick();
        check("lu3_sw", 32'(word(1)), 32'(W_SW));
`ifdef CTRL_PERF_CNT_EN
        check("lu3_count", bc[1], 32'd3);
`endif

        // Flush in second bubble cycle
        drive(1'b1, OP_LW, 5'd0, 5'd0, 5'd7);
        tick();
        drive(1'b1, OP_SW, 5'd0, 5'd7, 5'd0);
        tick();
        check("fl_bubble1", 32'(word(1)), 32'(W_BUB));
        flush = 1'b1;
        #1;
        check("fl_ready", 32'(id_ready[1]), 32'd1);
        tick();
        flush = 1'b0;
        check("fl_bubble", 32'(word(1)), 32'(W_BUB));
        #1;
        check("fl_run", 32'(id_ready[1]), 32'd1);
        tick();
        check("fl_sw", 32'(word(1)), 32'(W_SW));
`ifdef CTRL_PERF_CNT_EN
        check("fl_count", bc[1], 32'd4);
`endif

        // Downstream hold over a branch, then flush beats hold
        drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        check("hold_beq", 32'(word(1)), 32'(W_BEQ));
        drive(1'b1, OP_R, 5'd3, 5'd4, 5'd5);
        stall_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("hold_ready_%0d", k), 32'(id_ready[1]), 32'd0);
            tick();
            check($sformatf("hold_word_%0d", k), 32'(word(1)), 32'(W_BEQ));
        end
        flush = 1'b1;
        #1;
        check("hold_flush_ready", 32'(id_ready[1]), 32'd1);
        tick();
        check("hold_flush_word", 32'(word(1)), 32'(W_BUB));
        flush    = 1'b0;
        stall_in = 1'b0;

        // Illegal pulse held by downstream hold
        drive(1'b1, OP_BAD, 5'd0, 5'd0, 5'd0);
        tick();
        check("ill_set", 32'(word(1)), 32'(W_ILL));
        stall_in = 1'b1;
        tick();
        check("ill_held", 32'(word(1)), 32'(W_ILL));
        stall_in = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("ill_drop", 32'(word(1)), 32'(W_BUB));

        // Reset in the middle of a stall
        drive(1'b1, OP_LW, 5'd0, 5'd0, 5'd4);
        tick();
        drive(1'b1, OP_R, 5'd4, 5'd0, 5'd6);
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 32'(id_ready[1]), 32'd1);
        tick();
        check("rst_mid_word", 32'(word(1)), 32'(W_BUB));
        check("rst_mid_rd", 32'(ex_rd[1]), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("rst_mid_count", bc[1], 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("rst_mid_run", 32'(id_ready[1]), 32'd1);
        tick();
        check("rst_mid_add", 32'(word(1)), 32'(W_R));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Parametrised successor to the combinational main-opcode decoder. It decodes an extended RV32I opcode set: R, LW, SW, BEQ, ADDI, JAL, JALR, LUI.
- The decoded control bundle is held in an internal ID/EX control register.
- Detects load-use hazards and inserts a configurable number of bubbles. Honours downstream hold and branch/jump flush.
- Sits between the IF/ID register and the EX stage. Drives the fetch-hold signal back to IF/ID.

Parameters:
- ALUOP_W, 2, width of the ALUOp output; must be ≥2. Upper bits are zero.
- REG_ADDR_W, 5, register-index width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..3.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID instruction is valid
- opcode  in  7  instruction opcode field
- rs1  in  REG_ADDR_W  source register 1
- rs2  in  REG_ADDR_W  source register 2
- rd  in  REG_ADDR_W  destination register
- stall_in  in  1  downstream hold; freezes the ID/EX control register
- flush  in  1  taken branch/jump from EX; kills the ID instruction
- id_ready  out  1  combinational; 0 = IF/ID must hold its instruction
- out_valid  out  1  registered; EX holds a real instruction
- RegWrite, MemRead, MemWrite, Branch, Jump, ALUSrc, MemToReg  out  1 each  registered control bits
- ALUOp  out  ALUOP_W  registered ALU class
- ex_rd  out  REG_ADDR_W  registered rd of the instruction in EX
- illegal  out  1  registered one-cycle pulse for an unknown opcode

Behaviour:
- Decode table (RegWrite MemRead MemWrite Branch Jump ALUSrc ALUOp MemToReg):
  - R 0110011: 1 0 0 0 0 0 10 0
  - LW 0000011: 1 1 0 0 0 1 00 1
  - SW 0100011: 0 0 1 0 0 1 00 0
  - BEQ 1100011: 0 0 0 1 0 0 01 0
  - ADDI 0010011: 1 0 0 0 0 1 11 0
  - JAL 1101111: 1 0 0 0 1 0 00 0
  - JALR 1100111: 1 0 0 0 1 1 00 0
  - LUI 0110111: 1 0 0 0 0 1 00 0
- Register use: rs1 is used by R, LW, SW, BEQ, ADDI, JALR. rs2 is used by R, SW, BEQ.
- Bubble: out_valid=0, all control bits 0, ALUOp=0, ex_rd=0.
- Reset: the next edge forces a bubble, illegal=0, state RUN, counter=0. id_ready is 1 while rst=1. Reset mid-stall abandons the stall.
- Hazard condition (combinational): all of the following hold:
  - in_valid
  - out_valid & MemRead
  - ex_rd≠0
  - ex_rd==rs1 (rs1 used) or ex_rd==rs2 (rs2 used)
- States:
  - RUN: with no hazard, id_ready=1 and the decoded bundle is registered next edge (latency 1); out_valid=in_valid.
  - RUN with hazard: id_ready=0 and a bubble is registered. If STALL_CYCLES>1, go to STALL with counter=STALL_CYCLES-2; else stay in RUN.
  - STALL: id_ready=0 and a bubble is registered each cycle. When counter==0, return to RUN; otherwise decrement.
  - After the final bubble, the held instruction is accepted in RUN. The EX register no longer holds the load, so the hazard does not re-trigger.
- Priority, highest first: rst > flush > stall_in > hazard/STALL > normal decode.
- flush: bubble registered, illegal=0, state→RUN, counter=0, id_ready=1. flush overrides a simultaneous stall_in.
- stall_in (no flush): all registered outputs, state and counter hold; id_ready=0.
- Unknown opcode with in_valid: bubble registered, illegal=1 for one cycle. Suppressed by flush and held under stall_in.
- in_valid=0: bubble registered, no hazard check.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined: adds output bubble_count (32 bits). It increments once per hazard/STALL bubble actually registered, excluding cycles under stall_in. It wraps at 2^32-1→0 and is cleared by rst. Flush bubbles are not counted.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Decode sweep, STALL_CYCLES=1: each of the 8 opcodes with in_valid=1 → next cycle shows its table row; ADDI gives ALUOp=11, JALR gives Jump=1 and ALUSrc=1; opcode 1111111 → bubble with illegal=1 for one cycle.
- Load-use: LW rd=5, then ADD rs1=5 rs2=6 → id_ready=0 for 1 cycle, one bubble, then ADD registered with RegWrite=1 and ALUOp=10. Repeat with ex_rd=0 → no stall.
- STALL_CYCLES=3: LW rd=7, then SW rs2=7 → id_ready=0 for 3 consecutive cycles, 3 bubbles, then SW with MemWrite=1. With CTRL_PERF_CNT_EN, bubble_count=3.
- Flush during STALL (STALL_CYCLES=3, flush asserted in the 2nd bubble cycle) → state RUN, id_ready=1 the same cycle, bubble registered, counter cleared.
- stall_in=1 for 2 cycles while EX holds a BEQ → Branch=1, ALUOp=01 held constant and id_ready=0. Assert flush together with stall_in → bubble next edge.
- rst asserted mid-stall → next cycle all outputs 0, id_ready=1, out_valid=0; bubble_count=0 when enabled.
